// File: rtl/eth_pcs_tx_gbx_mux.sv
// ---------------------------------------------------------------------------
// eth_pcs_tx_gbx_mux
// 10GBASE-R PCS transmit back end. It accepts 66-bit encoded blocks through a
// valid/ready handshake, scrambles the 64-bit payload (x^58+x^39+1), gears the
// blocks into W_PMA-bit PMA words, and multiplexes in the PRBS31, square-wave
// and scrambled-idle test-pattern generators.
//
// Ports
//   i_clk        single clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_mode       0 normal, 1 PRBS31, 2 square wave, 3 scrambled idle
//   i_blk_valid  encoder presents a block
//   o_blk_ready  block taken when valid & ready (combinational)
//   i_sync       sync header (2'b01 data, 2'b10 control), never scrambled
//   i_pld        block payload, bit 0 transmitted first
//   o_pma_valid  o_pma_data holds a valid word
//   o_pma_data   PMA word, bit 0 transmitted first
//   o_underrun   one-cycle pulse: normal mode ran out of buffered bits
// ---------------------------------------------------------------------------
module eth_pcs_tx_gbx_mux #(
    parameter int unsigned W_PMA    = 32,
    parameter bit          SCR_EN   = 1'b1,
    parameter logic [57:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF,
    parameter int unsigned SQ_N     = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [1:0]       i_mode,
    input  logic             i_blk_valid,
    output logic             o_blk_ready,
    input  logic [1:0]       i_sync,
    input  logic [63:0]      i_pld,
    output logic             o_pma_valid,
    output logic [W_PMA-1:0] o_pma_data,
    output logic             o_underrun
);

    localparam int unsigned BUF_W = W_PMA + 66;
    localparam int unsigned FW    = $clog2(BUF_W);
    localparam int unsigned PW    = $clog2(2 * SQ_N);

    localparam logic [FW-1:0] W_F      = FW'(W_PMA);
    localparam logic [FW-1:0] BLK_F    = FW'(66);
    localparam logic [PW-1:0] SQ_HALF  = PW'(SQ_N);
    localparam logic [PW-1:0] SQ_LAST  = PW'(2 * SQ_N - 1);
    localparam logic [30:0]   PRBS_SEED = 31'h7FFF_FFFF;
    localparam logic [63:0]   IDLE_PLD  = 64'h0000_0000_0000_001E;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_PRBS   = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_IDLE   = 2'd3
    } mode_e;

    mode_e              mode_q;
    logic [BUF_W-1:0]   buf_q,  buf_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [57:0]        scr_q,  scr_d;
    logic [30:0]        prbs_q, prbs_d;
    logic [PW-1:0]      sq_q,   sq_d;
    logic               seen_q, seen_d;
    logic               valid_q, valid_d;
    logic [W_PMA-1:0]   data_q,  data_d;
    logic               under_q, under_d;

    logic               mode_chg;
    logic               fill_emit;
    logic [FW-1:0]      fill_rem;
    logic               room;
    logic               accept;
    logic               insert;
    logic               load;
    logic [1:0]         blk_sync;
    logic [63:0]        blk_pld;
    logic [63:0]        scr_out;
    logic [57:0]        scr_s;
    logic [BUF_W-1:0]   buf_shift;
    logic [W_PMA-1:0]   prbs_word;
    logic [30:0]        prbs_s;
    logic [W_PMA-1:0]   sq_word;
    logic [PW-1:0]      sq_ph;

    // -----------------------------------------------------------------------
    // Gearbox occupancy and handshake
    // -----------------------------------------------------------------------
    assign mode_chg = (mode_e'(i_mode) != mode_q);

    always_comb begin
        fill_emit = (fill_q >= W_F);
        fill_rem  = fill_emit ? (fill_q - W_F) : fill_q;
        room      = (fill_rem < W_F);
    end

    assign o_blk_ready = ~i_reset & (mode_q == MODE_NORMAL) & room;
    assign accept      = i_blk_valid & o_blk_ready;
    // Idle mode keeps the gearbox topped up with locally generated blocks.
    assign insert      = (mode_q == MODE_IDLE) & room;
    assign load        = accept | insert;
    assign blk_sync    = insert ? 2'b10    : i_sync;
    assign blk_pld     = insert ? IDLE_PLD : i_pld;

    // -----------------------------------------------------------------------
    // Self-synchronous scrambler, 64 serial steps per block
    // -----------------------------------------------------------------------
    always_comb begin
        scr_s   = scr_q;
        scr_out = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (SCR_EN) begin
                scr_out[i] = blk_pld[i] ^ scr_s[38] ^ scr_s[57];
                scr_s      = {scr_s[56:0], scr_out[i]};
            end else begin
                scr_out[i] = blk_pld[i];
            end
        end
        scr_d = load ? scr_s : scr_q;
    end

    // -----------------------------------------------------------------------
    // Gearbox buffer: emit from the pre-append contents, then append the new
    // block directly above the bits that remain.
    // -----------------------------------------------------------------------
    always_comb begin
        buf_shift = fill_emit ? (buf_q >> W_PMA) : buf_q;
        buf_d     = buf_shift;
        fill_d    = fill_rem;
        seen_d    = seen_q | accept;
        if (load) begin
            buf_d  = buf_shift | ({{(BUF_W - 66){1'b0}}, scr_out, blk_sync} << fill_rem);
            fill_d = fill_rem + BLK_F;
        end
        if (mode_chg) begin
            buf_d  = '0;
            fill_d = '0;
            seen_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // PRBS31 (x^31 + x^28 + 1), W_PMA serial steps per cycle
    // -----------------------------------------------------------------------
    always_comb begin
        prbs_s    = prbs_q;
        prbs_word = '0;
        for (int unsigned i = 0; i < W_PMA; i++) begin
            prbs_word[i] = prbs_s[30] ^ prbs_s[27];
            prbs_s       = {prbs_s[29:0], prbs_word[i]};
        end
        if (mode_chg) begin
            prbs_d = PRBS_SEED;
        end else if (mode_q == MODE_PRBS) begin
            prbs_d = prbs_s;
        end else begin
            prbs_d = prbs_q;
        end
    end

    // -----------------------------------------------------------------------
    // Square wave: SQ_N ones then SQ_N zeros, phase counted in bits
    // -----------------------------------------------------------------------
    always_comb begin
        sq_ph   = sq_q;
        sq_word = '0;
        for (int unsigned i = 0; i < W_PMA; i++) begin
            sq_word[i] = (sq_ph < SQ_HALF);
            sq_ph      = (sq_ph == SQ_LAST) ? '0 : sq_ph + 1'b1;
        end
        if (mode_chg) begin
            sq_d = '0;
        end else if (mode_q == MODE_SQUARE) begin
            sq_d = sq_ph;
        end else begin
            sq_d = sq_q;
        end
    end

    // -----------------------------------------------------------------------
    // Output selection; a mode change blanks the output for one cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        valid_d = 1'b0;
        data_d  = '0;
        under_d = 1'b0;
        if (!mode_chg) begin
            unique case (mode_q)
                MODE_NORMAL: begin
                    if (fill_emit) begin
                        valid_d = 1'b1;
                        data_d  = buf_q[W_PMA-1:0];
                    end else if (seen_q) begin
                        under_d = 1'b1;
                    end
                end
                MODE_PRBS: begin
                    valid_d = 1'b1;
                    data_d  = prbs_word;
                end
                MODE_SQUARE: begin
                    valid_d = 1'b1;
                    data_d  = sq_word;
                end
                MODE_IDLE: begin
                    if (fill_emit) begin
                        valid_d = 1'b1;
                        data_d  = buf_q[W_PMA-1:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mode_q  <= MODE_NORMAL;
            buf_q   <= '0;
            fill_q  <= '0;
            scr_q   <= SCR_SEED;
            prbs_q  <= PRBS_SEED;
            sq_q    <= '0;
            seen_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            under_q <= 1'b0;
        end else begin
            mode_q  <= mode_e'(i_mode);
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            scr_q   <= scr_d;
            prbs_q  <= prbs_d;
            sq_q    <= sq_d;
            seen_q  <= seen_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            under_q <= under_d;
        end
    end

    assign o_pma_valid = valid_q;
    assign o_pma_data  = data_q;
    assign o_underrun  = under_q;

endmodule

// File: tb/tb_eth_pcs_tx_gbx_mux.sv
// ---------------------------------------------------------------------------
// tb_eth_pcs_tx_gbx_mux
// Directed/randomised bench for eth_pcs_tx_gbx_mux (W_PMA=32, SQ_N=4). The
// reference keeps the transmitted bit stream as a queue and generates the
// scrambler and PRBS31 sequences from their recurrences on bit histories.
// ---------------------------------------------------------------------------
module tb_eth_pcs_tx_gbx_mux;

    localparam int W   = 32;
    localparam int SQN = 4;
    localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          blk_valid;
    logic          blk_ready;
    logic [1:0]    sync;
    logic [63:0]   pld;
    logic          pma_valid;
    logic [W-1:0]  pma_data;
    logic          underrun;

    int n_tests = 0;
    int n_fail  = 0;

    eth_pcs_tx_gbx_mux #(
        .W_PMA   (W),
        .SCR_EN  (1'b1),
        .SCR_SEED(SEED),
        .SQ_N    (SQN)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_mode     (mode),
        .i_blk_valid(blk_valid),
        .o_blk_ready(blk_ready),
        .i_sync     (sync),
        .i_pld      (pld),
        .o_pma_valid(pma_valid),
        .o_pma_data (pma_data),
        .o_underrun (underrun)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit        gq[$];       // bits waiting in the gearbox, oldest first
    bit        scr_h[$];    // last 58 scrambler output bits, newest at back
    bit        prbs_h[$];   // last 31 PRBS bits, newest at back
    int        sq_pos;
    int        m_mode;
    bit        m_seen;
    logic            e_valid;
    logic [W-1:0]    e_data;
    logic            e_und;
    int        n_acc;
    logic      last_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        gq.delete();
        scr_h.delete();
        for (int k = 57; k >= 0; k--) scr_h.push_back(SEED[k]);
        prbs_h.delete();
        for (int k = 0; k < 31; k++) prbs_h.push_back(1'b1);
        sq_pos = 0;
        m_mode = 0;
        m_seen = 1'b0;
    endtask

    task automatic prbs_restart();
        prbs_h.delete();
        for (int k = 0; k < 31; k++) prbs_h.push_back(1'b1);
    endtask

    // s(n) = d(n) ^ s(n-39) ^ s(n-58); sync bits go out unchanged first
    task automatic push_block(input logic [1:0] sy, input logic [63:0] pl);
        bit s;
        gq.push_back(sy[0]);
        gq.push_back(sy[1]);
        for (int i = 0; i < 64; i++) begin
            s = pl[i] ^ scr_h[scr_h.size() - 39] ^ scr_h[scr_h.size() - 58];
            scr_h.push_back(s);
            void'(scr_h.pop_front());
            gq.push_back(s);
        end
    endtask

    // One clock cycle: drive inputs, check ready, predict, clock, check outputs.
    task automatic cycle(input logic [1:0] md, input logic v, input logic [1:0] sy, input logic [63:0] pl);
        int  f, r;
        bit  emit, acc, chg, b;
        logic exp_rdy;
        mode = md; blk_valid = v; sync = sy; pld = pl;
        #1;
        f = gq.size();
        emit = (f >= W);
        r = emit ? f - W : f;
        exp_rdy = (m_mode == 0) && (r < W);
        chk("ready", blk_ready, exp_rdy);
        last_rdy = exp_rdy;
        acc = v && exp_rdy;
        if (acc) n_acc++;
        chg = (int'(md) != m_mode);
        e_valid = 1'b0; e_data = '0; e_und = 1'b0;
        case (m_mode)
            0, 3: begin
                if (emit) begin
                    e_valid = 1'b1;
                    for (int i = 0; i < W; i++) e_data[i] = gq.pop_front();
                end else if (m_mode == 0 && m_seen) begin
                    e_und = 1'b1;
                end
            end
            1: begin
                e_valid = 1'b1;
                for (int i = 0; i < W; i++) begin
                    b = prbs_h[prbs_h.size() - 31] ^ prbs_h[prbs_h.size() - 28];
                    prbs_h.push_back(b);
                    void'(prbs_h.pop_front());
                    e_data[i] = b;
                end
            end
            default: begin
                e_valid = 1'b1;
                for (int i = 0; i < W; i++) begin
                    e_data[i] = ((sq_pos % (2 * SQN)) < SQN);
                    sq_pos++;
                end
            end
        endcase
        if (acc) begin
            push_block(sy, pl);
            m_seen = 1'b1;
        end
        if (m_mode == 3 && r < W) push_block(2'b10, 64'h0000_0000_0000_001E);
        if (chg) begin
            e_valid = 1'b0; e_data = '0; e_und = 1'b0;
            gq.delete();
            m_seen = 1'b0;
            prbs_restart();
            sq_pos = 0;
            m_mode = int'(md);
        end
        @(posedge clk);
        #1;
        chk("pma_valid", pma_valid, e_valid);
        chk("pma_data", pma_data, e_data);
        chk("underrun", underrun, e_und);
    endtask

    task automatic rnd_cycle(input logic [1:0] md, input int pct_valid);
        cycle(md, ($urandom_range(0, 99) < pct_valid), ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01,
              {$urandom(), $urandom()});
    endtask

    // Asynchronous reset pulse away from the clock edge
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", pma_valid, 1'b0);
        chk("rst_data", pma_data, '0);
        chk("rst_under", underrun, 1'b0);
        chk("rst_ready", blk_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", pma_valid, 1'b0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic rdy_a[33];
        int   cnt;
        rst = 1'b1; mode = 2'd0; blk_valid = 1'b0; sync = 2'b01; pld = '0;
        n_acc = 0;
        model_reset();
        #1;
        chk("init_valid", pma_valid, 1'b0);
        chk("init_data", pma_data, '0);
        chk("init_ready", blk_ready, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // first block: sync visible at o_pma_data[1:0] two cycles after accept
        cycle(2'd0, 1'b1, 2'b01, 64'hFEDC_BA98_7654_3210);
        cycle(2'd0, 1'b1, 2'b10, {$urandom(), $urandom()});
        chk("sync_t2", pma_data[1:0], 2'b01);
        chk("valid_t2", pma_valid, 1'b1);

        // valid held high: steady accept rate and ready period
        for (int c = 0; c < 64; c++) rnd_cycle(2'd0, 100);
        n_acc = 0;
        for (int c = 0; c < 33; c++) begin
            rnd_cycle(2'd0, 100);
            rdy_a[c] = last_rdy;
        end
        chk("acc_per_33", n_acc, 16);
        cnt = 0;
        for (int c = 0; c < 33; c++) begin
            rnd_cycle(2'd0, 100);
            if (blk_ready !== 1'bx && last_rdy != rdy_a[c]) cnt++;
        end
        chk("ready_period33", cnt, 0);

        // zero payload: pure scrambler sequence from seed
        do_reset();
        for (int c = 0; c < 2070; c++) cycle(2'd0, 1'b1, 2'b01, 64'h0);

        // starvation after four blocks
        do_reset();
        for (int c = 0; c < 7; c++) rnd_cycle(2'd0, 100);
        for (int c = 0; c < 3; c++) rnd_cycle(2'd0, 0);
        for (int c = 0; c < 40; c++) rnd_cycle(2'd0, 100);
        for (int c = 0; c < 300; c++) rnd_cycle(2'd0, 70);

        // PRBS31
        rnd_cycle(2'd1, 50);
        rnd_cycle(2'd1, 50);
        chk("prbs_first", pma_data, 32'h7000_0000);
        for (int c = 0; c < 40; c++) rnd_cycle(2'd1, 50);

        // square wave
        rnd_cycle(2'd2, 50);
        for (int c = 0; c < 20; c++) begin
            rnd_cycle(2'd2, 50);
            chk("sq_word", pma_data, 32'h0F0F_0F0F);
        end

        // scrambled idle
        for (int c = 0; c < 150; c++) rnd_cycle(2'd3, 50);

        // back to normal, quick 0->1->0 switch, then reset mid-block
        for (int c = 0; c < 100; c++) rnd_cycle(2'd0, 80);
        for (int c = 0; c < 5; c++) rnd_cycle(2'd1, 80);
        for (int c = 0; c < 30; c++) rnd_cycle(2'd0, 80);
        do_reset();
        cycle(2'd0, 1'b1, 2'b10, {$urandom(), $urandom()});
        cycle(2'd0, 1'b1, 2'b01, {$urandom(), $urandom()});
        chk("sync_after_rst", pma_data[1:0], 2'b10);
        for (int c = 0; c < 60; c++) rnd_cycle(2'd0, 90);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
